edge_logger: RTL and testbench

EDGE_LOGGER -- requirements
Module: edge_logger

---
 rtl/edge_logger.sv | 101 ++++++++++
 tb/tb_edge_logger.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/edge_logger.sv
// Edge logger: timestamps rising/falling edges of sig_in and queues them in a
// small FIFO. When the FIFO is full and no pop happens, new events are dropped and a sticky overflow flag is set.
module edge_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sig_in,
    input  logic                     en,
    input  logic                     clr_ovf,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TS_W-1:0]          evt_ts,
    output logic                     evt_rise,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [TS_W-1:0] r_ts;
    logic            r_sig_d;
    logic            r_primed;
    logic [LW-1:0]   r_level;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic            r_ovf;
    logic [TS_W:0]   r_mem [DEPTH];

    logic w_edge;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Edge detection is held off until the first edge after reset, so the
    // reset value of r_sig_d can never produce a spurious event.
    assign w_edge  = r_primed & en & (sig_in ^ r_sig_d);
    assign w_full  = (r_level == FULL_LVL);
    assign w_empty = (r_level == '0);
    assign w_pop   = ~w_empty & evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push  = w_edge & (~w_full | w_pop);
    assign w_drop  = w_edge & w_full & ~w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts     <= '0;
            r_sig_d  <= 1'b0;
            r_primed <= 1'b0;
        end else begin
            if (en)
                r_ts <= r_ts + TS_W'(1);
            r_sig_d  <= sig_in;
            r_primed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: reading is qualified by a nonzero level.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {r_ts, sig_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (clr_ovf)
            r_ovf <= 1'b0;
        else if (w_drop)
            r_ovf <= 1'b1;
    end

    assign evt_valid = ~w_empty;
    assign evt_ts    = w_empty ? '0 : r_mem[r_rd_ptr][TS_W:1];
    assign evt_rise  = w_empty ? 1'b0 : r_mem[r_rd_ptr][0];
    assign level     = r_level;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_edge_logger.sv
// Bench for edge_logger: queue-based event model compared every cycle, plus
// hand-computed pins for the directed scenarios and a randomized soak.
module tb_edge_logger;
    localparam int TSW = 4;
    localparam int DEP = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sig_in = 1'b0;
    logic            en = 1'b0;
    logic            clr_ovf = 1'b0;
    logic            evt_ready = 1'b0;
    logic            evt_valid;
    logic [TSW-1:0]  evt_ts;
    logic            evt_rise;
    logic [3:0]      level;
    logic            overflow;

    edge_logger #(.TS_W(TSW), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .en(en), .clr_ovf(clr_ovf),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ts(evt_ts),
        .evt_rise(evt_rise), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // behavioural model: events are a queue of (timestamp, rise) pairs
    int mq_ts[$];
    bit mq_rise[$];
    int m_ts;
    bit m_sigd, m_primed, m_ovf, m_edge, m_drop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq_ts.delete(); mq_rise.delete();
            m_ts = 0; m_sigd = 0; m_primed = 0; m_ovf = 0;
        end else begin
            m_edge = m_primed && en && (sig_in != m_sigd);
            m_drop = 0;
            if (evt_ready && mq_ts.size() > 0) begin
                void'(mq_ts.pop_front());
                void'(mq_rise.pop_front());
            end
            if (m_edge) begin
                if (mq_ts.size() < DEP) begin
                    mq_ts.push_back(m_ts);
                    mq_rise.push_back(sig_in);
                end else m_drop = 1;
            end
            if (clr_ovf) m_ovf = 0;
            else if (m_drop) m_ovf = 1;
            if (en) m_ts = (m_ts + 1) % (1 << TSW);
            m_sigd = sig_in;
            m_primed = 1;
        end
    end

    // literal expectations requested by the stimulus, checked at the next negedge
    int pin_req = 0, pin_seen = 0;
    bit pin_v, pin_r, pin_o;
    int pin_lv, pin_ts;

    int total = 0, bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int e_lv;
        bit e_v;
        e_lv = mq_ts.size();
        e_v  = (e_lv != 0);
        chk("evt_valid", int'(evt_valid), int'(e_v));
        chk("level", int'(level), e_lv);
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("evt_ts", int'(evt_ts), e_v ? mq_ts[0] : 0);
        chk("evt_rise", int'(evt_rise), e_v ? int'(mq_rise[0]) : 0);
        if (pin_req != pin_seen) begin
            pin_seen = pin_req;
            chk("pin_valid", int'(evt_valid), int'(pin_v));
            chk("pin_level", int'(level), pin_lv);
            chk("pin_ts", int'(evt_ts), pin_ts);
            chk("pin_rise", int'(evt_rise), int'(pin_r));
            chk("pin_ovf", int'(overflow), int'(pin_o));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pin(input bit v, input int lv, input int ts, input bit r, input bit o);
        pin_v = v; pin_lv = lv; pin_ts = ts; pin_r = r; pin_o = o;
        pin_req++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        tick(2);
        pin(0, 0, 0, 0, 0);
        // single rise sampled at ts=5
        rst = 1'b0; en = 1'b1; sig_in = 1'b0;
        tick(5);
        sig_in = 1'b1;
        tick(1);
        pin(1, 1, 5, 1, 0);
        tick(1);

        // 3-cycle pulse into a stalled consumer, then drain
        do_reset();
        sig_in = 1'b0; evt_ready = 1'b0;
        tick(10);
        sig_in = 1'b1;
        tick(3);
        sig_in = 1'b0;
        tick(1);
        pin(1, 2, 10, 1, 0);
        evt_ready = 1'b1;
        tick(1);
        pin(1, 1, 13, 0, 0);
        tick(1);
        pin(0, 0, 0, 0, 0);
        evt_ready = 1'b0;
        tick(1);

        // overflow after 10 toggles, then clear
        do_reset();
        sig_in = 1'b0;
        tick(2);
        repeat (10) begin
            sig_in = ~sig_in;
            tick(1);
        end
        pin(1, 8, 2, 1, 1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        pin(1, 8, 2, 1, 0);
        tick(1);

        // full with simultaneous pop and push: no drop, then drain in order
        sig_in = ~sig_in; evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        pin(1, 8, 3, 0, 0);
        tick(1);
        evt_ready = 1'b1;
        tick(8);
        evt_ready = 1'b0;
        pin(0, 0, 0, 0, 0);
        tick(1);

        // ts wraps past 15, en=0 blocks events and holds ts
        do_reset();
        sig_in = 1'b0;
        tick(20);
        en = 1'b0;
        repeat (6) begin
            sig_in = ~sig_in;
            tick(1);
        end
        pin(0, 0, 0, 0, 0);
        en = 1'b1; sig_in = 1'b1;
        tick(1);
        pin(1, 1, 4, 1, 0);

        // reset mid-operation with three queued events, sig_in high across release
        sig_in = 1'b0; tick(1);
        sig_in = 1'b1; tick(1);
        pin(1, 3, 4, 1, 0);
        tick(1);
        rst = 1'b1;
        pin(0, 0, 0, 0, 0);
        tick(1);
        rst = 1'b0;
        tick(3);
        pin(0, 0, 0, 0, 0);
        tick(1);

        // randomized soak
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) sig_in = ~sig_in;
            en        = ($urandom_range(0, 7) != 0);
            evt_ready = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
            clr_ovf   = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            tick(1);
        end
        rst = 1'b0; clr_ovf = 1'b0; evt_ready = 1'b0;
        tick(2);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
